// File: rtl/pair_bus_pkg.sv
// Shared definitions for the 227-bit pair bus: widths, tags, framing and word packing.
package pair_bus_pkg;

  localparam int PAIR_W     = 227;
  localparam int PAYLOAD_W  = 192;
  localparam int SEQ_W      = 32;
  localparam int ENTRY_W    = PAYLOAD_W + 1;  // {last flag, payload}
  localparam int FRAME_LEN  = 16;
  localparam int EMIT_SLOTS = 14;

  localparam logic [1:0] TAG_DATA = 2'b00;
  localparam logic [1:0] TAG_LAST = 2'b01;
  localparam logic [1:0] TAG_NULL = 2'b11;

  // Receivers drop any word whose tag bits are both set.
  localparam logic [PAIR_W-1:0] NULL_WORD =
    {{SEQ_W{1'b0}}, TAG_NULL, 1'b0, {PAYLOAD_W{1'b0}}};

  // Pack a buffered entry into a bus word: {seq, tag, reserved, payload}.
  function automatic logic [PAIR_W-1:0] make_word(
    input logic [SEQ_W-1:0]   seq,
    input logic [ENTRY_W-1:0] entry
  );
    logic [1:0] tag;
    if (entry[ENTRY_W-1]) begin
      tag = TAG_LAST;
    end else begin
      tag = TAG_DATA;
    end
    return {seq, tag, 1'b0, entry[PAYLOAD_W-1:0]};
  endfunction

endpackage

// File: rtl/pair_entry_buf.sv
// Register-based FIFO of pair entries. A push at full is accepted only when a
// pop frees a slot in the same cycle; the caller decides what a refused push means.
module pair_entry_buf
  import pair_bus_pkg::*;
#(
  parameter  int DEPTH = 16,
  parameter  int W     = ENTRY_W,
  localparam int AW    = $clog2(DEPTH),
  localparam int LW    = AW + 1
) (
  input  logic          clk,
  input  logic          clr_n,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic [LW-1:0] level,
  output logic          full,
  output logic          empty
);

  logic [W-1:0]  mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [LW-1:0] level_r;
  logic          push_ok_s;
  logic          pop_ok_s;

  assign full      = (level_r == LW'(DEPTH));
  assign empty     = (level_r == {LW{1'b0}});
  assign pop_ok_s  = pop & ~empty;
  assign push_ok_s = push & (~full | pop_ok_s);
  assign level     = level_r;
  assign dout      = mem_r[rd_ptr_r];

  // Storage write; contents need no reset because level gates every read.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= din;
    end
  end

  // Pointers wrap naturally at DEPTH; occupancy follows accepted push/pop.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      level_r  <= {LW{1'b0}};
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   level_r <= level_r + LW'(1);
        2'b01:   level_r <= level_r - LW'(1);
        default: level_r <= level_r;
      endcase
    end
  end

endmodule

// File: rtl/pair_entry_fifo.sv
// Host-to-pipeline injector: buffers host pair records and drives them onto the
// pair bus in the emitting slots of a fixed frame, null words elsewhere.
module pair_entry_fifo
  import pair_bus_pkg::*;
#(
  parameter  int DEPTH = 16,
  parameter  int FRAME = FRAME_LEN,
  parameter  int SLOTS = EMIT_SLOTS,
  localparam int SW    = $clog2(FRAME),
  localparam int LW    = $clog2(DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [PAYLOAD_W-1:0] host_data,
  input  logic                 last_in,
  input  logic                 write_ctrl,
  output logic [PAIR_W-1:0]    out,
  output logic                 frame_start,
  output logic                 qfull,
  output logic                 overflow,
  output logic [LW-1:0]        level
);

  logic               host_prev_r;
  logic [SW-1:0]      slot_r;
  logic [SEQ_W-1:0]   seq_r;
  logic [PAIR_W-1:0]  out_r;
  logic               overflow_r;

  logic               push_s;
  logic               pop_s;
  logic               drop_s;
  logic               emit_slot_s;
  logic               full_s;
  logic               empty_s;
  logic [ENTRY_W-1:0] head_s;

  assign push_s      = write_ctrl & ~host_prev_r;
  assign emit_slot_s = (slot_r < SW'(SLOTS));
  assign pop_s       = emit_slot_s & ~empty_s;
  // A push at full survives only if this cycle's pop makes room.
  assign drop_s      = push_s & full_s & ~pop_s;

  assign out         = out_r;
  assign frame_start = (slot_r == SW'(0));
  assign qfull       = full_s;
  assign overflow    = overflow_r;

  pair_entry_buf #(
    .DEPTH (DEPTH),
    .W     (ENTRY_W)
  ) u_buf (
    .clk   (clk),
    .clr_n (reset),
    .push  (push_s),
    .pop   (pop_s),
    .din   ({last_in, host_data}),
    .dout  (head_s),
    .level (level),
    .full  (full_s),
    .empty (empty_s)
  );

  // Remember the last strobe level so a held strobe yields one push.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      host_prev_r <= 1'b0;
    end else begin
      host_prev_r <= write_ctrl;
    end
  end

  // Free-running frame slot counter; reset parks it on the last slot so the
  // first active edge starts a frame.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      slot_r <= SW'(FRAME - 1);
    end else if (slot_r == SW'(FRAME - 1)) begin
      slot_r <= SW'(0);
    end else begin
      slot_r <= slot_r + SW'(1);
    end
  end

  // Output word register and sequence numbering of emitted data words.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_r <= NULL_WORD;
      seq_r <= {SEQ_W{1'b0}};
    end else if (pop_s) begin
      out_r <= make_word(seq_r, head_s);
      seq_r <= seq_r + 32'd1;
    end else begin
      out_r <= NULL_WORD;
      seq_r <= seq_r;
    end
  end

  // Sticky record of any push lost to a full buffer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow_r <= 1'b0;
    end else if (drop_s) begin
      overflow_r <= 1'b1;
    end else begin
      overflow_r <= overflow_r;
    end
  end

endmodule

// File: tb/tb_pair_entry_fifo.sv
// Directed bench for pair_entry_fifo with hand-computed expected bus words.
module tb_pair_entry_fifo;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [191:0] host_data = 192'd0;
  logic         last_in = 1'b0;
  logic         write_ctrl = 1'b0;
  logic [226:0] out_w;
  logic         frame_start;
  logic         qfull;
  logic         overflow;
  logic [4:0]   level;

  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [226:0] NULL_W = {32'd0, 2'b11, 1'b0, 192'd0};

  pair_entry_fifo dut (
    .clk         (clk),
    .reset       (reset),
    .host_data   (host_data),
    .last_in     (last_in),
    .write_ctrl  (write_ctrl),
    .out         (out_w),
    .frame_start (frame_start),
    .qfull       (qfull),
    .overflow    (overflow),
    .level       (level)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [226:0] obs, input logic [226:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [191:0] pay(input int n);
    logic [31:0] v;
    v = 32'hA5A5_0000 + 32'(n);
    return {6{v}};
  endfunction

  function automatic logic [226:0] word_of(input int seq, input int n, input bit last);
    logic [31:0] s;
    logic [1:0]  t;
    s = 32'(seq);
    t = last ? 2'b01 : 2'b00;
    return {s, t, 1'b0, pay(n)};
  endfunction

  task automatic push(input int n, input bit last);
    host_data  = pay(n);
    last_in    = last;
    write_ctrl = 1'b1;
    tick();
    write_ctrl = 1'b0;
    last_in    = 1'b0;
    tick();
  endtask

  task automatic apply_reset();
    write_ctrl = 1'b0;
    reset = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  // Align to the cycle in slot 14 (bounded wait on frame_start).
  task automatic to_slot14();
    int budget;
    budget = 0;
    while (frame_start !== 1'b1 && budget < 40) begin
      tick();
      budget++;
    end
    chk("sync_frame", frame_start, 1);
    repeat (14) tick();
  endtask

  // Expected stream for a full frame of 14 words then more: j counts edges
  // after releasing the hold in slot 14.
  function automatic logic [226:0] stream_exp(input int j, input int last_n, input int sub_n);
    if (j >= 3 && j <= 16) return word_of(j - 3, j - 2, 1'b0);
    if (j >= 19 && j <= 18 + last_n) begin
      if (j - 4 == 17 && sub_n != 0) return word_of(j - 5, sub_n, 1'b0);
      return word_of(j - 5, j - 4, 1'b0);
    end
    return NULL_W;
  endfunction

  initial begin
    // ---- reset values ----
    #1 reset = 1'b0;
    #1;
    chk("rst_out", out_w, NULL_W);
    chk("rst_level", level, 0);
    chk("rst_qfull", qfull, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_frame_start", frame_start, 0);
    tick();
    reset = 1'b1;

    // ---- idle: null words, frame_start every 16 cycles ----
    for (int i = 0; i < 48; i++) begin
      tick();
      chk("idle_frame_start", frame_start, (i % 16 == 0) ? 1 : 0);
      chk("idle_out", out_w, NULL_W);
    end
    chk("idle_level", level, 0);

    // ---- three pushes before slot 0, third marked last ----
    apply_reset();
    force dut.pop_s = 1'b0;
    push(1, 1'b0);
    push(2, 1'b0);
    push(3, 1'b1);
    chk("three_level", level, 3);
    to_slot14();
    release dut.pop_s;
    for (int j = 1; j <= 18; j++) begin
      tick();
      if (j == 3)      chk("three_w0", out_w, word_of(0, 1, 1'b0));
      else if (j == 4) chk("three_w1", out_w, word_of(1, 2, 1'b0));
      else if (j == 5) chk("three_w2", out_w, word_of(2, 3, 1'b1));
      else             chk("three_null", out_w, NULL_W);
    end
    chk("three_level_end", level, 0);

    // ---- 20 records: 14 in frame 0, 6 in frame 1 ----
    apply_reset();
    force dut.pop_s = 1'b0;
    for (int n = 1; n <= 16; n++) push(n, 1'b0);
    chk("twenty_qfull", qfull, 1);
    chk("twenty_no_ovf", overflow, 0);
    to_slot14();
    release dut.pop_s;
    for (int j = 1; j <= 34; j++) begin
      tick();
      chk("twenty_out", out_w, stream_exp(j, 6, 0));
      if (j >= 3 && j <= 9 && (j % 2 == 1)) begin
        host_data  = pay(17 + (j - 3) / 2);
        write_ctrl = 1'b1;
      end else begin
        write_ctrl = 1'b0;
      end
    end
    chk("twenty_level_end", level, 0);
    chk("twenty_ovf_end", overflow, 0);

    // ---- overflow at full, then push+pop at full ----
    apply_reset();
    force dut.pop_s = 1'b0;
    for (int n = 1; n <= 16; n++) push(n, 1'b0);
    chk("full_ovf_before", overflow, 0);
    push(17, 1'b0);
    chk("full_level", level, 16);
    chk("full_qfull", qfull, 1);
    chk("full_ovf", overflow, 1);
    to_slot14();
    release dut.pop_s;
    tick();
    tick();
    host_data  = pay(99);
    write_ctrl = 1'b1;
    tick();
    write_ctrl = 1'b0;
    chk("pushpop_level", level, 16);
    chk("pushpop_qfull", qfull, 1);
    chk("pushpop_out", out_w, word_of(0, 1, 1'b0));
    for (int j = 4; j <= 21; j++) begin
      tick();
      chk("pushpop_stream", out_w, stream_exp(j, 3, 99));
    end
    chk("pushpop_ovf_sticky", overflow, 1);

    // ---- strobe held high: exactly one push ----
    apply_reset();
    force dut.pop_s = 1'b0;
    host_data  = pay(5);
    write_ctrl = 1'b1;
    repeat (10) tick();
    chk("held_level", level, 1);
    write_ctrl = 1'b0;
    tick();
    chk("held_level_after", level, 1);
    release dut.pop_s;

    // ---- reset mid-frame with 5 entries queued in slot 7 ----
    apply_reset();
    force dut.pop_s = 1'b0;
    for (int n = 1; n <= 12; n++) push(n, 1'b0);
    to_slot14();
    release dut.pop_s;
    repeat (9) tick();
    chk("mid_level", level, 5);
    chk("mid_out", out_w, word_of(6, 7, 1'b0));
    reset = 1'b0;
    #1;
    chk("mid_rst_out", out_w, NULL_W);
    chk("mid_rst_level", level, 0);
    chk("mid_rst_qfull", qfull, 0);
    tick();
    reset = 1'b1;
    host_data  = pay(77);
    write_ctrl = 1'b1;
    tick();
    write_ctrl = 1'b0;
    chk("post_rst_null", out_w, NULL_W);
    chk("post_rst_level", level, 1);
    tick();
    chk("post_rst_seq0", out_w, word_of(0, 77, 1'b0));
    chk("post_rst_level0", level, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
